// File: rtl/dpwm_mux_sched_if.sv
// Bundle between the DPWM phase request logic and the duty-mux scheduler.
//   req        : per-phase request, bit i = phase i wants the duty mux
//   period_end : one-cycle pulse at the end of each PWM period
//   lock       : holds the current grant across period_end
//                (only when DPWM_SCHED_LOCK_EN is defined)
//   sel        : 4:1 duty mux select
//   grant      : one-hot grant, zero when nothing is granted
//   busy       : scheduler is granting or inside the dead-time guard
// Modports: master = scheduler (drives sel/grant/busy),
//           slave  = request/DPWM side (drives req/period_end/lock).
interface dpwm_mux_sched_if;
  logic [3:0] req;
  logic       period_end;
`ifdef DPWM_SCHED_LOCK_EN
  logic       lock;
`endif
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

`ifdef DPWM_SCHED_LOCK_EN
  modport master (input req, period_end, lock, output sel, grant, busy);
  modport slave  (output req, period_end, lock, input sel, grant, busy);
`else
  modport master (input req, period_end, output sel, grant, busy);
  modport slave  (output req, period_end, input sel, grant, busy);
`endif
endinterface

// File: rtl/dpwm_mux_sched.sv
// Round-robin scheduler sharing the 4:1 duty-word mux between four DPWM
// phase channels. Each grant is held for one DPWM period (or until the
// phase drops its request), followed by DEAD_CYC idle cycles with no grant
// before the next phase is selected.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous reset, active low
//   bus     : dpwm_mux_sched_if.master (req, period_end, [lock], sel, grant, busy)
// Parameters:
//   DEAD_CYC : guard cycles between release and next grant (0..15, 0 = none)
//   CNT_W    : dead-time counter width, 2**CNT_W > DEAD_CYC
// Optional feature macro: DPWM_SCHED_LOCK_EN adds the lock input, which
// makes a GRANT ignore period_end while lock is high.
module dpwm_mux_sched #(
  parameter int DEAD_CYC = 2,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  dpwm_mux_sched_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam bit               NO_GUARD    = (DEAD_CYC == 0);
  localparam int               DEAD_LOAD_I = NO_GUARD ? 0 : DEAD_CYC - 1;
  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_LOAD_I);

  logic [1:0]       state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       sel_q, sel_nx;
  logic [3:0]       grant_q, grant_nx;
  logic             busy_q;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             period_rel;
  logic             rel_now;
  logic             do_arb;
  logic [2:0]       arb;

  // Returns {found, index}: first set request searching p+1, p+2, p+3, p.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int n = 4; n >= 1; n--) begin
      c = p + 2'(n);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

`ifdef DPWM_SCHED_LOCK_EN
  assign period_rel = bus.period_end && !bus.lock;
`else
  assign period_rel = bus.period_end;
`endif

  // A request drop and period_end in the same cycle form one release.
  assign rel_now = !bus.req[sel_q] || period_rel;
  assign arb     = pick(bus.req, ptr);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel_q;
    grant_nx = grant_q;
    cnt_nx   = cnt;
    do_arb   = 1'b0;
    case (state)
      ST_IDLE: do_arb = 1'b1;
      ST_GRANT: begin
        if (rel_now) begin
          grant_nx = 4'b0000;
          if (NO_GUARD) begin
            do_arb = 1'b1;
          end else begin
            state_nx = ST_GUARD;
            cnt_nx   = DEAD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        if (cnt == '0) do_arb = 1'b1;
        else           cnt_nx = cnt - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
    // sel is only updated on a new grant so the mux output stays put
    // through the guard and while idle.
    if (do_arb) begin
      if (arb[2]) begin
        state_nx = ST_GRANT;
        grant_nx = 4'b0001 << arb[1:0];
        sel_nx   = arb[1:0];
        ptr_nx   = arb[1:0];
      end else begin
        state_nx = ST_IDLE;
        grant_nx = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= 2'd3;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      sel_q   <= sel_nx;
      grant_q <= grant_nx;
      busy_q  <= (state_nx != ST_IDLE);
      cnt     <= cnt_nx;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dpwm_mux_sched.sv
// Bench for dpwm_mux_sched: one instance with a 2-cycle guard (a) and one
// with no guard (b), both fed the same inputs. Directed scenario tasks plus
// a randomized run compared against a cycle-level reference model.
module tb_dpwm_mux_sched;
  localparam int DA = 2;
  localparam int DB = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       pe = 1'b0;
  logic       lock_v = 1'b0;
  int         checks = 0;
  int         errors = 0;

  dpwm_mux_sched_if ifa ();
  dpwm_mux_sched_if ifb ();

  assign ifa.req = req;
  assign ifb.req = req;
  assign ifa.period_end = pe;
  assign ifb.period_end = pe;
`ifdef DPWM_SCHED_LOCK_EN
  assign ifa.lock = lock_v;
  assign ifb.lock = lock_v;
`endif

  dpwm_mux_sched #(.DEAD_CYC(DA), .CNT_W(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  dpwm_mux_sched #(.DEAD_CYC(DB), .CNT_W(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  always #5 clk = ~clk;

  logic [3:0] g_obs [2];
  logic [1:0] s_obs [2];
  logic       b_obs [2];
  assign g_obs[0] = ifa.grant;
  assign g_obs[1] = ifb.grant;
  assign s_obs[0] = ifa.sel;
  assign s_obs[1] = ifb.sel;
  assign b_obs[0] = ifa.busy;
  assign b_obs[1] = ifb.busy;

  // Reference model: owner phase (-1 none), remaining zero-grant cycles of
  // the guard, last granted phase (lowest priority next), current select.
  int dead [2] = '{DA, DB};
  int m_owner [2];
  int m_gap [2];
  int m_last [2];
  int m_sel [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_gap[k] = 0; m_last[k] = 3; m_sel[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] r, input bit p, input bit lk);
    for (int k = 0; k < 2; k++) begin
      bit arb_now = 1'b0;
      bit found = 1'b0;
      if (m_owner[k] >= 0) begin
        if (!r[m_owner[k]] || (p && !lk)) begin
          if (dead[k] == 0) arb_now = 1'b1;
          else begin m_owner[k] = -1; m_gap[k] = dead[k]; end
        end
      end else if (m_gap[k] > 1) begin
        m_gap[k] = m_gap[k] - 1;
      end else begin
        arb_now = 1'b1;
      end
      if (arb_now) begin
        m_gap[k] = 0;
        m_owner[k] = -1;
        for (int n = 1; n <= 4; n++) begin
          int c;
          c = (m_last[k] + n) % 4;
          if (!found && r[c]) begin
            found = 1'b1; m_owner[k] = c; m_last[k] = c; m_sel[k] = c;
          end
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = 4'b0000; pe = 1'b0; lock_v = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b0000; pe = 1'b0;
    tick(); tick();
    checks++;
    if ({ifa.sel, ifa.grant, ifa.busy} !== 7'b0) begin
      errors++; $display("FAIL reset_a got %b want 0000000", {ifa.sel, ifa.grant, ifa.busy});
    end
    checks++;
    if ({ifb.sel, ifb.grant, ifb.busy} !== 7'b0) begin
      errors++; $display("FAIL reset_b got %b want 0000000", {ifb.sel, ifb.grant, ifb.busy});
    end
    reset_n = 1'b1;
    req = 4'b1111;
    tick();
    checks++;
    if (ifa.grant !== 4'b0001 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL first_grant got %b/%b want 0001/1", ifa.grant, ifa.busy);
    end
    req = 4'b0100;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ifa.sel, ifa.grant, ifa.busy} !== 7'b0) begin
      errors++; $display("FAIL async_reset_a got %b want 0000000", {ifa.sel, ifa.grant, ifa.busy});
    end
    checks++;
    if ({ifb.sel, ifb.grant, ifb.busy} !== 7'b0) begin
      errors++; $display("FAIL async_reset_b got %b want 0000000", {ifb.sel, ifb.grant, ifb.busy});
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (ifa.grant !== 4'b0100 || ifa.sel !== 2'd2) begin
      errors++; $display("FAIL post_reset_grant got %b sel %0d want 0100 sel 2", ifa.grant, ifa.sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [$];
    int gaps [$];
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] last_g;
    int zrun;
    do_reset();
    req = 4'b1111;
    zrun = 0;
    last_g = 4'b0000;
    for (int c = 0; c < 60; c++) begin
      pe = ((c % 8) == 7);
      tick();
      if (ifa.grant == 4'b0000) zrun++;
      else begin
        if (zrun > 0 || seq.size() == 0 || ifa.grant != last_g) begin
          if (seq.size() != 0) gaps.push_back(zrun);
          seq.push_back(ifa.grant);
        end
        zrun = 0;
        last_g = ifa.grant;
      end
    end
    pe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= seq.size()) begin
        errors++; $display("FAIL rr_seq[%0d] got none want %b", i, exp_seq[i]);
      end else if (seq[i] !== exp_seq[i]) begin
        errors++; $display("FAIL rr_seq[%0d] got %b want %b", i, seq[i], exp_seq[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= gaps.size()) begin
        errors++; $display("FAIL rr_gap[%0d] got none want %0d", i, DA);
      end else if (gaps[i] != DA) begin
        errors++; $display("FAIL rr_gap[%0d] got %0d want %0d", i, gaps[i], DA);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (ifa.grant !== 4'b0010 || ifa.sel !== 2'd1) begin
      errors++; $display("FAIL er_grant got %b sel %0d want 0010 sel 1", ifa.grant, ifa.sel);
    end
    tick(); tick();
    req = 4'b0000;
    tick();
    checks++;
    if (ifa.grant !== 4'b0000 || ifa.sel !== 2'd1 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL er_release got %b sel %0d busy %b want 0000 sel 1 busy 1", ifa.grant, ifa.sel, ifa.busy);
    end
    req = 4'b0011;
    tick();
    checks++;
    if (ifa.grant !== 4'b0000) begin
      errors++; $display("FAIL er_guard got %b want 0000", ifa.grant);
    end
    tick();
    checks++;
    if (ifa.grant !== 4'b0001 || ifa.sel !== 2'd0) begin
      errors++; $display("FAIL er_regrant got %b sel %0d want 0001 sel 0", ifa.grant, ifa.sel);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0011;
    tick(); tick();
    req = 4'b1110;
    pe = 1'b1;
    tick();
    pe = 1'b0;
    checks++;
    if (ifa.grant !== 4'b0000 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL sim_release got %b busy %b want 0000 busy 1", ifa.grant, ifa.busy);
    end
    tick();
    checks++;
    if (ifa.grant !== 4'b0000 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL sim_guard got %b busy %b want 0000 busy 1", ifa.grant, ifa.busy);
    end
    tick();
    checks++;
    if (ifa.grant !== 4'b0010 || ifa.sel !== 2'd1) begin
      errors++; $display("FAIL sim_next got %b sel %0d want 0010 sel 1", ifa.grant, ifa.sel);
    end
  endtask

  task automatic test_dead_zero();
    do_reset();
    req = 4'b0101;
    tick();
    checks++;
    if (ifb.grant !== 4'b0001) begin
      errors++; $display("FAIL dz_first got %b want 0001", ifb.grant);
    end
    pe = 1'b1;
    tick();
    pe = 1'b0;
    checks++;
    if (ifb.grant !== 4'b0100 || ifb.sel !== 2'd2 || ifb.busy !== 1'b1) begin
      errors++; $display("FAIL dz_switch got %b sel %0d busy %b want 0100 sel 2 busy 1", ifb.grant, ifb.sel, ifb.busy);
    end
    tick();
    pe = 1'b1;
    tick();
    pe = 1'b0;
    checks++;
    if (ifb.grant !== 4'b0001 || ifb.sel !== 2'd0 || ifb.busy !== 1'b1) begin
      errors++; $display("FAIL dz_back got %b sel %0d busy %b want 0001 sel 0 busy 1", ifb.grant, ifb.sel, ifb.busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (ifb.grant !== 4'b0000 || ifb.busy !== 1'b0) begin
      errors++; $display("FAIL dz_idle got %b busy %b want 0000 busy 0", ifb.grant, ifb.busy);
    end
  endtask

`ifdef DPWM_SCHED_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock_v = 1'b1;
    req = 4'b1000;
    tick();
    for (int i = 0; i < 3; i++) begin
      pe = 1'b1;
      tick();
      pe = 1'b0;
      tick();
      checks++;
      if (ifa.grant !== 4'b1000) begin
        errors++; $display("FAIL lock_hold[%0d] got %b want 1000", i, ifa.grant);
      end
    end
    lock_v = 1'b0;
    pe = 1'b1;
    tick();
    pe = 1'b0;
    checks++;
    if (ifa.grant !== 4'b0000 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL lock_release got %b busy %b want 0000 busy 1", ifa.grant, ifa.busy);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3, 0) == 0) req = 4'($urandom);
      pe = ($urandom_range(4, 0) == 0);
`ifdef DPWM_SCHED_LOCK_EN
      lock_v = ($urandom_range(3, 0) == 0);
`endif
      tick();
      model_step(req, pe, lock_v);
      for (int k = 0; k < 2; k++) begin
        eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
        checks++;
        if (g_obs[k] !== eg || s_obs[k] !== 2'(m_sel[k]) ||
            b_obs[k] !== ((m_owner[k] >= 0) || (m_gap[k] > 0))) begin
          errors++;
          $display("FAIL rand[%0d] dut%0d got grant %b sel %0d busy %b want grant %b sel %0d busy %b",
                   c, k, g_obs[k], s_obs[k], b_obs[k], eg, m_sel[k],
                   ((m_owner[k] >= 0) || (m_gap[k] > 0)));
        end
      end
    end
    pe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_release();
    test_simultaneous();
    test_dead_zero();
`ifdef DPWM_SCHED_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
